// File: rtl/cpu_debug_ctrl.sv
// Run-control block for a CPU debug port: halt/run/single-step sequencing,
// PC breakpoint comparators and retired-instruction / active-cycle counters.
module cpu_debug_ctrl #(
  parameter int  ADDR_W    = 32,
  parameter int  NUM_BP    = 4,
  parameter int  CNT_W     = 32,
  parameter bit  RESET_RUN = 1'b0,
  localparam int IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [CNT_W-1:0]  step_count,
  input  logic              bp_wr_en,
  input  logic [IDX_W-1:0]  bp_wr_idx,
  input  logic [ADDR_W-1:0] bp_wr_addr,
  input  logic              bp_wr_valid,
  input  logic              instr_done,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              cnt_clr,
  output logic              cpu_en,
  output logic              halted,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [IDX_W-1:0]  bp_hit_idx,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               hit_d;
  logic               bp_match;
  logic [IDX_W-1:0]   bp_match_idx;
  logic [ADDR_W-1:0]  bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0]  bp_valid_q;
  logic               bp_wr_ok;

  assign state    = state_q;
  assign bp_wr_ok = bp_wr_en && (int'(bp_wr_idx) < NUM_BP);

  // Descending scan so the lowest matching comparator wins.
  always_comb begin
    bp_match     = 1'b0;
    bp_match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == next_pc)) begin
        bp_match     = 1'b1;
        bp_match_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    hit_d   = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (step_req) begin
          state_d = ST_STEP;
          rem_d   = (step_count == '0) ? CNT_W'(1) : step_count;
        end else if (run_req) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_STEP: begin
        if (instr_done) begin
          if (state_q == ST_STEP) rem_d = rem_q - CNT_W'(1);
          hit_d = bp_match;
          if (bp_match || halt_req ||
              (state_q == ST_STEP && rem_q == CNT_W'(1))) begin
            state_d = ST_HALT;
          end
        end else if (halt_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (instr_done) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      rem_q      <= '0;
      cpu_en     <= RESET_RUN;
      halted     <= !RESET_RUN;
      bp_hit     <= 1'b0;
      bp_hit_idx <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cpu_en  <= (state_d != ST_HALT);
      halted  <= (state_d == ST_HALT);
      bp_hit  <= hit_d;
      if (hit_d) bp_hit_idx <= bp_match_idx;
    end
  end

  // NOTE: only the valid bits are reset; an address is never looked at while its entry is invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_valid_q <= '0;
    end else if (bp_wr_ok) begin
      bp_valid_q[bp_wr_idx] <= bp_wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (bp_wr_ok) bp_addr_q[bp_wr_idx] <= bp_wr_addr;
  end

  // Counters key off the registered cpu_en, so a retire reported while halted is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (cpu_en)               cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (cpu_en && instr_done) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Scoreboard bench for cpu_debug_ctrl: a behavioural model predicts every
// cycle's outputs; a negedge monitor compares two DUT widths against it.
module tb_cpu_debug_ctrl;

  localparam int ADDR_W = 32;
  localparam int NUM_BP = 4;
  localparam int CNT_W  = 32;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run_req, halt_req, step_req;
  logic [CNT_W-1:0]  step_count;
  logic              bp_wr_en;
  logic [IDX_W-1:0]  bp_wr_idx;
  logic [ADDR_W-1:0] bp_wr_addr;
  logic              bp_wr_valid;
  logic              instr_done;
  logic [ADDR_W-1:0] next_pc;
  logic              cnt_clr;

  logic              cpu_en, halted, bp_hit;
  logic [1:0]        state;
  logic [IDX_W-1:0]  bp_hit_idx;
  logic [CNT_W-1:0]  retired_cnt, cycle_cnt;

  logic              w_cpu_en, w_halted, w_bp_hit;
  logic [1:0]        w_state;
  logic [IDX_W-1:0]  w_bp_hit_idx;
  logic [3:0]        w_retired_cnt, w_cycle_cnt;
  logic [3:0]        w_step_count;

  assign w_step_count = step_count[3:0];

  always #5 clk = ~clk;

  cpu_debug_ctrl #(.ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .RESET_RUN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .step_count(step_count), .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx),
    .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .instr_done(instr_done),
    .next_pc(next_pc), .cnt_clr(cnt_clr), .cpu_en(cpu_en), .halted(halted), .state(state),
    .bp_hit(bp_hit), .bp_hit_idx(bp_hit_idx), .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
  );

  cpu_debug_ctrl #(.ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .CNT_W(4), .RESET_RUN(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .step_count(w_step_count), .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx),
    .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .instr_done(instr_done),
    .next_pc(next_pc), .cnt_clr(cnt_clr), .cpu_en(w_cpu_en), .halted(w_halted), .state(w_state),
    .bp_hit(w_bp_hit), .bp_hit_idx(w_bp_hit_idx), .retired_cnt(w_retired_cnt),
    .cycle_cnt(w_cycle_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run-control rules kept as plain variables, one update per clock.
  typedef enum int {M_HALT = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3} mstate_t;

  typedef struct {
    logic [1:0]  state;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  idx;
    logic [31:0] retired;
    logic [31:0] cycles;
  } exp_t;

  exp_t        sb_q[$];
  mstate_t     m_state;
  int unsigned m_rem;
  logic [31:0] m_bp_addr [NUM_BP];
  bit          m_bp_valid [NUM_BP];
  logic [31:0] m_ret, m_cyc;
  bit          m_hit;
  logic [1:0]  m_idx;

  function automatic void model_reset();
    m_state = M_HALT;
    m_rem   = 0;
    m_ret   = '0;
    m_cyc   = '0;
    m_hit   = 1'b0;
    m_idx   = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      m_bp_valid[i] = 1'b0;
      m_bp_addr[i]  = '0;
    end
  endfunction

  function automatic void model_step();
    mstate_t ns = m_state;
    bit      en = (m_state != M_HALT);
    int      hit_i = -1;
    exp_t    e;
    for (int i = 0; i < NUM_BP; i++)
      if (hit_i < 0 && m_bp_valid[i] && m_bp_addr[i] == next_pc) hit_i = i;
    m_hit = 1'b0;
    if (cnt_clr) begin
      m_cyc = '0;
      m_ret = '0;
    end else begin
      if (en) m_cyc = m_cyc + 1;
      if (en && instr_done) m_ret = m_ret + 1;
    end
    case (m_state)
      M_HALT: begin
        if (step_req) begin
          ns    = M_STEP;
          m_rem = (step_count == 0) ? 1 : int'(step_count);
        end else if (run_req) begin
          ns = M_RUN;
        end
      end
      M_RUN, M_STEP: begin
        if (instr_done) begin
          if (m_state == M_STEP) m_rem = m_rem - 1;
          if (hit_i >= 0) begin
            m_hit = 1'b1;
            m_idx = hit_i[1:0];
            ns    = M_HALT;
          end else if (halt_req || (m_state == M_STEP && m_rem == 0)) begin
            ns = M_HALT;
          end
        end else if (halt_req) begin
          ns = M_DRAIN;
        end
      end
      M_DRAIN: if (instr_done) ns = M_HALT;
      default: ns = M_HALT;
    endcase
    if (bp_wr_en) begin
      m_bp_addr[bp_wr_idx]  = bp_wr_addr;
      m_bp_valid[bp_wr_idx] = bp_wr_valid;
    end
    m_state   = ns;
    e.state   = 2'(int'(ns));
    e.cpu_en  = (ns != M_HALT);
    e.halted  = (ns == M_HALT);
    e.bp_hit  = m_hit;
    e.idx     = m_idx;
    e.retired = m_ret;
    e.cycles  = m_cyc;
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("state", state, e.state);
      check("cpu_en", cpu_en, e.cpu_en);
      check("halted", halted, e.halted);
      check("bp_hit", bp_hit, e.bp_hit);
      check("bp_hit_idx", bp_hit_idx, e.idx);
      check("retired_cnt", retired_cnt, e.retired);
      check("cycle_cnt", cycle_cnt, e.cycles);
      check("w_state", w_state, e.state);
      check("w_bp_hit", w_bp_hit, e.bp_hit);
      check("w_retired_cnt", w_retired_cnt, e.retired[3:0]);
      check("w_cycle_cnt", w_cycle_cnt, e.cycles[3:0]);
    end
  end

  task automatic clear_inputs();
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; step_count = '0;
    bp_wr_en = 1'b0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_valid = 1'b0;
    instr_done = 1'b0; next_pc = '0; cnt_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  task automatic retire(input logic [31:0] pc);
    instr_done = 1'b1;
    next_pc    = pc;
    tick();
    clear_inputs();
  endtask

  task automatic bp_write(input int idx, input logic [31:0] addr, input logic vld);
    bp_wr_en = 1'b1; bp_wr_idx = 2'(idx); bp_wr_addr = addr; bp_wr_valid = vld;
    tick();
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_state", state, 2'b00);
    check("rst_halted", halted, 1'b1);
    check("rst_cpu_en", cpu_en, 1'b0);
    check("rst_bp_hit", bp_hit, 1'b0);
    check("rst_retired", retired_cnt, 0);
    check("rst_cycles", cycle_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r_before;
    clear_inputs();
    model_reset();
    #3;
    check("init_state", state, 2'b00);
    check("init_idx", bp_hit_idx, 0);
    #4;
    rst_n = 1'b1;

    // Three single-steps, one retire every 7 cycles.
    do_reset();
    step_req = 1'b1; step_count = 3; tick(); clear_inputs();
    repeat (3) begin
      idle(6);
      retire(32'h100);
    end
    check("step3_state", state, 2'b00);
    check("step3_retired", retired_cnt, 3);
    check("step3_cycles", cycle_cnt, 21);
    check("step3_cpu_en", cpu_en, 1'b0);

    // Breakpoint halt, then resume from the breakpoint address.
    do_reset();
    bp_write(0, 32'h8, 1'b1);
    bp_write(1, 32'h4, 1'b0);
    bp_write(3, 32'h10, 1'b1);
    run_req = 1'b1; tick(); clear_inputs();
    idle(2); retire(32'h0);
    idle(2); retire(32'h4);
    check("bp_invalid_ignored", state, 2'b01);
    idle(2); retire(32'h8);
    check("bp_halt_state", state, 2'b00);
    check("bp_hit_pulse", bp_hit, 1'b1);
    check("bp_hit_idx0", bp_hit_idx, 0);
    tick();
    check("bp_hit_one_cycle", bp_hit, 1'b0);
    run_req = 1'b1; tick(); clear_inputs();
    check("resume_state", state, 2'b01);
    idle(2); retire(32'hC);
    check("resume_no_rehalt", state, 2'b01);
    idle(1); retire(32'h10);
    check("bp_hit_idx3", bp_hit_idx, 3);

    // Protocol-error retire while halted is not counted.
    r_before = m_ret;
    retire(32'h50);
    check("halt_retire_ignored", retired_cnt, r_before);

    // halt_req mid-instruction drains.
    run_req = 1'b1; tick(); clear_inputs();
    idle(3);
    halt_req = 1'b1; tick(); clear_inputs();
    check("drain_state", state, 2'b11);
    check("drain_cpu_en", cpu_en, 1'b1);
    idle(2);
    check("drain_hold", state, 2'b11);
    r_before = m_ret;
    retire(32'h20);
    check("drain_done_state", state, 2'b00);
    check("drain_retired", retired_cnt, r_before + 1);

    // halt_req coincident with a retire skips DRAIN.
    run_req = 1'b1; tick(); clear_inputs();
    idle(2);
    halt_req = 1'b1; retire(32'h40);
    check("halt_direct", state, 2'b00);

    // step_req beats run_req; step_count 0 behaves as 1.
    step_req = 1'b1; run_req = 1'b1; step_count = 0; tick(); clear_inputs();
    check("step_wins", state, 2'b10);
    idle(1); retire(32'h44);
    check("step0_as_1", state, 2'b00);

    // Reset in the middle of a STEP.
    bp_write(2, 32'h30, 1'b1);
    step_req = 1'b1; step_count = 5; tick(); clear_inputs();
    idle(1); retire(32'h24);
    idle(1); retire(32'h28);
    check("mid_step_state", state, 2'b10);
    do_reset();
    run_req = 1'b1; tick(); clear_inputs();
    retire(32'h30);
    check("bp_cleared", state, 2'b01);
    halt_req = 1'b1; retire(32'h34);

    // 4-bit counter wrap and clear priority.
    cnt_clr = 1'b1; tick(); clear_inputs();
    run_req = 1'b1; tick(); clear_inputs();
    idle(17);
    check("wrap_w_cycles", w_cycle_cnt, 1);
    check("wrap_cycles", cycle_cnt, 17);
    cnt_clr = 1'b1; tick(); clear_inputs();
    check("clr_prio_w", w_cycle_cnt, 0);
    check("clr_prio", cycle_cnt, 0);
    halt_req = 1'b1; retire(32'h60);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      run_req    = ($urandom_range(0, 15) == 0);
      halt_req   = ($urandom_range(0, 19) == 0);
      step_req   = ($urandom_range(0, 15) == 0);
      step_count = CNT_W'($urandom_range(0, 6));
      instr_done = ($urandom_range(0, 2) == 0);
      next_pc    = ADDR_W'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 29) == 0) begin
        bp_wr_en    = 1'b1;
        bp_wr_idx   = IDX_W'($urandom_range(0, 3));
        bp_wr_addr  = ADDR_W'($urandom_range(0, 15) * 4);
        bp_wr_valid = ($urandom_range(0, 3) != 0);
      end
      cnt_clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    idle(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
